// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU: datapath width and the opcode encoding
// of the m select input.
package alu_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_CMP = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

endpackage

// File: rtl/alu_addsub.sv
// Combinational 4-bit adder/subtractor with carry-in. When sub=1, cin is a
// borrow-in and carry reports borrow-out (a < b + cin, unsigned).
module alu_addsub
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH:0]   total;

  // Subtraction is a + ~b + ~cin, so a borrow is the absence of a carry-out.
  assign b_eff = sub ? ~b : b;
  assign c_eff = sub ? ~cin : cin;
  assign total = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, c_eff};

  assign sum      = total[WIDTH-1:0];
  assign carry    = sub ? ~total[WIDTH] : total[WIDTH];
  assign overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_4bit.sv
// Registered 4-bit ALU, one-cycle latency with out_valid strobe.
// Define ALU_FLAGS_EN to add registered zero/carry/negative flag outputs.
module alu_4bit
  import alu_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [2:0]       m,
  output logic [WIDTH-1:0] r,
  output logic             overflow,
  output logic             out_valid
`ifdef ALU_FLAGS_EN
  ,
  output logic             zero,
  output logic             carry,
  output logic             negative
`endif
);

  op_e              op;
  logic             as_sub;
  logic             as_cin;
  logic [WIDTH-1:0] as_sum;
  logic             as_carry;
  logic             as_ovf;
  logic [7:0]       shl_wide;
  logic [7:0]       shr_wide;
  logic [WIDTH-1:0] res_r;
  logic             res_ov;

  assign op = op_e'(m);

  // CMP reuses the subtractor with no borrow-in: borrow-out is a<b, zero diff is a==b.
  assign as_sub = (op == OP_SUB) || (op == OP_CMP);
  assign as_cin = (op == OP_CMP) ? 1'b0 : cin;

  alu_addsub u_addsub (
    .a        (a),
    .b        (b),
    .cin      (as_cin),
    .sub      (as_sub),
    .sum      (as_sum),
    .carry    (as_carry),
    .overflow (as_ovf)
  );

  assign shl_wide = {4'b0000, a} << b[1:0];
  assign shr_wide = {a, 4'b0000} >> b[1:0];

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned, which would infer a latch.
    res_r  = '0;
    res_ov = 1'b0;
    unique case (op)
      OP_ADD: begin
        res_r  = as_sum;
        res_ov = as_ovf;
      end
      OP_SUB: begin
        res_r  = as_sum;
        res_ov = as_ovf;
      end
      OP_CMP: res_r = {1'b0, ~as_carry & (as_sum != '0), as_sum == '0, as_carry};
      OP_AND: res_r = a & b;
      OP_OR:  res_r = a | b;
      OP_XOR: res_r = a ^ b;
      OP_SHL: begin
        res_r  = shl_wide[3:0];
        res_ov = |shl_wide[7:4];
      end
      OP_SHR: begin
        res_r  = shr_wide[7:4];
        res_ov = |shr_wide[3:0];
      end
      default: ;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic res_c;
  assign res_c = ((op == OP_ADD) || (op == OP_SUB)) ? as_carry : 1'b0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r         <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
`ifdef ALU_FLAGS_EN
      zero      <= 1'b0;
      carry     <= 1'b0;
      negative  <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        r        <= res_r;
        overflow <= res_ov;
`ifdef ALU_FLAGS_EN
        zero     <= (res_r == '0);
        carry    <= res_c;
        negative <= res_r[WIDTH-1];
`endif
      end
    end
  end

endmodule

// File: tb/tb_alu_4bit.sv
// Scoreboard bench for alu_4bit: expected results are queued at drive time and
// compared when out_valid is due; also checks hold, timing and async reset.
module tb_alu_4bit;
  import alu_pkg::*;

  typedef struct {
    logic [3:0] r;
    logic       ov;
    logic       z;
    logic       c;
    logic       n;
  } exp_t;

  typedef struct {
    op_e        op;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] r;
    logic       ov;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a;
  logic [3:0] b;
  logic       cin;
  logic [2:0] m;
  logic [3:0] r;
  logic       overflow;
  logic       out_valid;
`ifdef ALU_FLAGS_EN
  logic       zero;
  logic       carry;
  logic       negative;
`endif

  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb[$];
  exp_t last;

  alu_4bit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .m         (m),
    .r         (r),
    .overflow  (overflow),
    .out_valid (out_valid)
`ifdef ALU_FLAGS_EN
    ,
    .zero      (zero),
    .carry     (carry),
    .negative  (negative)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Integer reference model, written independently of the adder structure.
  function automatic exp_t model(input op_e op, input logic [3:0] xa, input logic [3:0] xb,
                                 input logic xc);
    exp_t e;
    int ua = int'(xa);
    int ub = int'(xb);
    int sa = (ua >= 8) ? ua - 16 : ua;
    int sb_ = (ub >= 8) ? ub - 16 : ub;
    int t;
    int st;
    int p = 1 << (ub % 4);
    e.ov = 1'b0;
    e.c  = 1'b0;
    case (op)
      OP_ADD: begin
        t = ua + ub + int'(xc);  st = sa + sb_ + int'(xc);
        e.r = 4'(t % 16);  e.c = (t > 15);  e.ov = (st > 7) || (st < -8);
      end
      OP_SUB: begin
        t = ua - ub - int'(xc);  st = sa - sb_ - int'(xc);
        e.r = 4'((t + 32) % 16);  e.c = (t < 0);  e.ov = (st > 7) || (st < -8);
      end
      OP_CMP: e.r = {1'b0, ua > ub, ua == ub, ua < ub};
      OP_AND: e.r = xa & xb;
      OP_OR:  e.r = xa | xb;
      OP_XOR: e.r = xa ^ xb;
      OP_SHL: begin
        t = ua * p;  e.r = 4'(t % 16);  e.ov = (t >= 16);
      end
      default: begin
        e.r = 4'(ua / p);  e.ov = (ua % p) != 0;
      end
    endcase
    e.z = (e.r == 4'd0);
    e.n = e.r[3];
    return e;
  endfunction

  task automatic send(input op_e op, input logic [3:0] xa, input logic [3:0] xb, input logic xc);
    @(negedge clk);
    m = op;  a = xa;  b = xb;  cin = xc;  in_valid = 1'b1;
    sb.push_back(model(op, xa, xb, xc));
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
    a = 4'($urandom);  b = 4'($urandom);  m = 3'($urandom);  cin = 1'($urandom);
  endtask

  // Monitor: after each edge, out_valid must reflect the sampled in_valid.
  always @(posedge clk) begin
    logic v_s;
    exp_t e;
    v_s = in_valid && rst_n;
    #1;
    if (rst_n) begin
      check("out_valid", out_valid, v_s);
      if (v_s) begin
        check("sb_nonempty", sb.size() > 0, 1'b1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          last = e;
        end
      end
      check(v_s ? "r" : "r_hold", r, last.r);
      check(v_s ? "overflow" : "ov_hold", overflow, last.ov);
`ifdef ALU_FLAGS_EN
      check("zero", zero, last.z);
      check("carry", carry, last.c);
      check("negative", negative, last.n);
`endif
    end
  end

  task automatic check_reset_outputs();
    check("rst_r", r, 4'd0);
    check("rst_ov", overflow, 1'b0);
    check("rst_out_valid", out_valid, 1'b0);
`ifdef ALU_FLAGS_EN
    check("rst_flags", {zero, carry, negative}, 3'b000);
`endif
  endtask

  vec_t vecs[$] = '{
    '{OP_ADD, 4'd2,  4'd1, 1'b0, 4'd3,  1'b0},
    '{OP_ADD, 4'd5,  4'd2, 1'b0, 4'd7,  1'b0},
    '{OP_ADD, 4'd10, 4'd2, 1'b0, 4'd12, 1'b0},
    '{OP_ADD, 4'd5,  4'd4, 1'b0, 4'd9,  1'b1},
    '{OP_ADD, 4'd2,  4'd1, 1'b1, 4'd4,  1'b0},
    '{OP_SUB, 4'd2,  4'd1, 1'b0, 4'd1,  1'b0},
    '{OP_SUB, 4'd5,  4'd2, 1'b0, 4'd3,  1'b0},
    '{OP_SUB, 4'd14, 4'd2, 1'b0, 4'd12, 1'b0},
    '{OP_SUB, 4'd7,  4'd8, 1'b0, 4'd15, 1'b1},
    '{OP_CMP, 4'd2,  4'd1, 1'b0, 4'b0100, 1'b0},
    '{OP_CMP, 4'd5,  4'd5, 1'b1, 4'b0010, 1'b0},
    '{OP_CMP, 4'd1,  4'd3, 1'b0, 4'b0001, 1'b0},
    '{OP_AND, 4'd14, 4'd2, 1'b0, 4'd2,  1'b0},
    '{OP_OR,  4'd5,  4'd2, 1'b0, 4'd7,  1'b0},
    '{OP_XOR, 4'd14, 4'd2, 1'b0, 4'd12, 1'b0},
    '{OP_SHL, 4'd5,  4'd2, 1'b0, 4'd4,  1'b1},
    '{OP_SHR, 4'd14, 4'd2, 1'b0, 4'd3,  1'b1},
    '{OP_SHR, 4'd2,  4'd1, 1'b0, 4'd1,  1'b0},
    '{OP_SHL, 4'd9,  4'd12, 1'b1, 4'd9, 1'b0}
  };

  initial begin
    exp_t e;
    rst_n = 1'b1;  in_valid = 1'b0;  a = '0;  b = '0;  cin = 1'b0;  m = '0;
    last = '{default: '0};
    #2 rst_n = 1'b0;
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors: expected r/ov are hand-derived constants, flags from the model.
    foreach (vecs[i]) begin
      @(negedge clk);
      m = vecs[i].op;  a = vecs[i].a;  b = vecs[i].b;  cin = vecs[i].cin;  in_valid = 1'b1;
      e = model(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      e.r = vecs[i].r;
      e.ov = vecs[i].ov;
      sb.push_back(e);
    end
    idle();
    idle();

    // in_valid pulses two cycles apart: out_valid only after each, r held between.
    send(OP_ADD, 4'd2, 4'd1, 1'b0);
    idle();
    send(OP_XOR, 4'd14, 4'd2, 1'b0);
    idle();
    idle();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(3) == 0) idle();
      else send(op_e'($urandom_range(7)), 4'($urandom), 4'($urandom), 1'($urandom));
    end
    idle();

    // Mid-stream async reset discards the in-flight SUB.
    send(OP_ADD, 4'd5, 4'd4, 1'b0);
    send(OP_SUB, 4'd7, 4'd8, 1'b0);
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    last = '{default: '0};
    #1 check_reset_outputs();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    send(OP_OR, 4'd5, 4'd2, 1'b0);
    idle();
    idle();

    check("sb_drained", 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_4bit.md
# alu_4bit

Registered 4-bit arithmetic/logic unit with carry-in, 3-bit operation select and an overflow flag. It sits in the datapath as a single-stage execute unit. Operands and opcode are sampled on each clock edge, and the result is presented one cycle later together with a valid strobe.

## Interface
- No parameters; width is fixed at 4 bits.
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  qualifies a, b, cin, m this cycle
- a  input  4  operand A (unsigned; two's complement for overflow)
- b  input  4  operand B
- cin  input  1  carry-in for ADD, borrow-in for SUB; ignored by other ops
- m  input  3  operation select
- r  output  4  registered result
- overflow  output  1  registered overflow/shift-out flag
- out_valid  output  1  r/overflow hold a new result this cycle

## Operation
- m=0 ADD: r = (a + b + cin) mod 16. overflow = signed two's-complement overflow.
- m=1 SUB: r = (a − b − cin) mod 16. overflow = signed overflow of the subtraction.
- m=2 CMP, unsigned compare: r = {1'b0, a>b, a==b, a<b}. overflow = 0.
- m=3 AND: r = a & b. overflow = 0.
- m=4 OR: r = a | b. overflow = 0.
- m=5 XOR: r = a ^ b. overflow = 0.
- m=6 SHL: r = a << b[1:0], zero fill. overflow = 1 if any 1 bit is shifted out.
- m=7 SHR: r = a >> b[1:0], logical. overflow = 1 if any 1 bit is shifted out.
- b[3:2] is ignored for shifts; a shift amount of 0 gives r = a, overflow = 0.
- All 8 codes are defined, so there is no illegal-opcode behaviour.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on r/overflow after edge N and hold until the next accepted operation.
- out_valid is registered from in_valid; it pulses high for exactly the cycles following accepted inputs.
- When in_valid=0, r and overflow hold their previous values and out_valid goes to 0.
- Back-to-back in_valid is supported at full throughput, one result per cycle; there is no backpressure.
- Reset: while rst_n=0, r=0, overflow=0, out_valid=0, applied asynchronously. The first edge after deassertion may accept inputs.
- Reset asserted mid-stream discards the in-flight result; no stale out_valid appears after release.

## Configuration
- ALU_FLAGS_EN defined adds three registered outputs:
  - zero: r==0.
  - carry: carry-out for ADD; borrow-out (a < b+cin unsigned) for SUB; 0 for other ops.
  - negative: r[3].
  - All three have the same latency, hold behaviour and reset value (0) as r.
- ALU_FLAGS_EN undefined: these ports and their logic do not exist.

## Structure
- Shared package alu_pkg holds the 3-bit opcode localparams/enum (OP_ADD … OP_SHR) and the width constant 4.
- One sub-module, alu_addsub: combinational 4-bit add/subtract with cin, producing sum, carry/borrow and signed overflow, shared by ADD and SUB.
- The top level holds the opcode decode mux and output registers.

## Test plan
- ADD, cin=0: 2+1 → r=3, ov=0; 5+2 → r=7, ov=0; 10+2 → r=12, ov=0; 5+4 → r=9, ov=1. With cin=1, 2+1 → r=4.
- SUB: 2−1 → r=1, ov=0; 5−2 → r=3; 14−2 → r=12, ov=0; 7−(−8) (a=7, b=8) → r=15, ov=1.
- CMP: (2,1) → r=4'b0100; (5,5) → r=4'b0010; (1,3) → r=4'b0001; ov=0 in all cases.
- Logic and shifts: 14&2 → 2; 5|2 → 7; 14^2 → 12; SHL 5 by 2 → r=4, ov=1; SHR 14 by 2 → r=3, ov=1; SHR 2 by 1 → r=1, ov=0.
- Timing/hold: in_valid pulses at cycles 0 and 2 → out_valid high at cycles 1 and 3 only; r holds between them.
- Reset: assert rst_n=0 asynchronously mid-stream → r=0, ov=0, out_valid=0 immediately; after release, the next accepted operation produces its correct result one cycle later.
